// File: rtl/bmp_vga_streamer.sv
// Buffers the 24-bit bitmap pixel stream in a small FIFO and scans it out
// as 640x480@60 VGA, reporting frame/vblank/underflow status to software.
module bmp_vga_streamer #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        in_vblank,
    output logic [15:0] underflow_cnt,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_L   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_L   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_L = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_L   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_L   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_L = VW'(V_TOTAL - 1);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    logic          pix_phase_q, pix_phase_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, vblank_q, vblank_d;
    logic [15:0]   uf_q, uf_d;
    logic [23:0]   fifo_mem [FIFO_DEPTH];

    logic pix_en, active, hs_n, vs_n, flush, fifo_empty, push, pop;

    always_comb begin
        pix_en      = pix_phase_q;
        active      = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
        hs_n        = !((h_cnt_q >= H_SS_L) && (h_cnt_q < H_SE_L));
        vs_n        = !((v_cnt_q >= V_SS_L) && (v_cnt_q < V_SE_L));
        flush       = pix_en && (h_cnt_q == '0) && (v_cnt_q == V_ACT_L);
        fifo_empty  = (count_q == '0);
        pix_ready   = Reset_n && (count_q < DEPTH_L);
        // Flush wins over a coincident push; pops never bypass an empty FIFO.
        push        = pix_valid && pix_ready && !flush;
        pop         = pix_en && active && !fifo_empty;
        frame_start = pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_comb begin
        pix_phase_d = !pix_phase_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST_L) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST_L) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    always_comb begin
        rgb_d    = rgb_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        blank_d  = blank_q;
        vblank_d = vblank_q;
        uf_d     = uf_q;
        if (pix_en) begin
            hs_d     = hs_n;
            vs_d     = vs_n;
            blank_d  = active;
            vblank_d = (v_cnt_q >= V_ACT_L);
            rgb_d    = pop ? fifo_mem[rd_ptr_q] : '0;
            if (active && fifo_empty && (uf_q != '1)) uf_d = uf_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pix_phase_q <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            vblank_q    <= 1'b0;
            uf_q        <= '0;
        end else begin
            pix_phase_q <= pix_phase_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            vblank_q    <= vblank_d;
            uf_q        <= uf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr_q] <= pix_data;
    end

    assign VGA_CLK       = pix_phase_q;
    assign VGA_R         = rgb_q[23:16];
    assign VGA_G         = rgb_q[15:8];
    assign VGA_B         = rgb_q[7:0];
    assign VGA_HS        = hs_q;
    assign VGA_VS        = vs_q;
    assign VGA_BLANK_N   = blank_q;
    assign VGA_SYNC_N    = 1'b0;
    assign in_vblank     = vblank_q;
    assign underflow_cnt = uf_q;

endmodule

// File: doc/bmp_vga_streamer.md
Name: bmp_vga_streamer

Overview:
- Downstream consumer of the 24-bit bitmap pixel stream exported by the NIOS system (bmp_pixout_export).
- Buffers pixels in a small FIFO and generates 640x480@60 VGA timing from the 50 MHz system clock.
- Pops one pixel per active VGA position and drives the board VGA DAC pins directly.
- Reports frame boundaries, vblank and underflow status back to software.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  synchronous active-low reset
- pix_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- pix_valid  in  1  pix_data valid this cycle
- pix_ready  out  1  FIFO can accept; push occurs when pix_valid & pix_ready
- frame_start  out  1  one-Clk pulse at h=0,v=0 pixel tick
- in_vblank  out  1  high while v >= V_ACTIVE
- underflow_cnt  out  16  saturating count of active pixels shown black due to empty FIFO
- VGA_R, VGA_G, VGA_B  out  8 each  colour to DAC
- VGA_CLK  out  1  25 MHz pixel clock
- VGA_HS, VGA_VS  out  1  active-low syncs
- VGA_BLANK_N  out  1  high during active video
- VGA_SYNC_N  out  1  tied 0

Behaviour:
- All state is updated on rising Clk; reset is checked only at the Clk edge.
- Reset values:
  - pix_phase=0, h_cnt=0, v_cnt=0.
  - FIFO empty; pix_ready=0 while Reset_n=0.
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_SYNC_N=0.
  - frame_start=0, underflow_cnt=0, in_vblank=0.
- Pixel clock:
  - pix_phase toggles every Clk; VGA_CLK=pix_phase.
  - pix_en = (pix_phase==1): one Clk in two.
- Counters advance only on pix_en.
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of H parameters = 800), then wraps to 0.
  - v_cnt increments on h_cnt wrap and runs 0..V_TOTAL-1 (525), then wraps to 0.
- Decode per pixel tick, from the counter values before increment:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hs_n = !(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)).
  - vs_n = !(v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)).
- Output registers load on pix_en, giving one-Clk latency from counter state to pins.
  - VGA_HS=hs_n, VGA_VS=vs_n, VGA_BLANK_N=active.
  - If active and FIFO non-empty: RGB = FIFO head, and the head is popped this cycle.
  - If active and FIFO empty: RGB=0, underflow_cnt+1 (saturates at 0xFFFF), no pop.
  - If not active: RGB=0, no pop.
- frame_start = pix_en && h==0 && v==0 (one-Clk pulse). in_vblank is registered with the sync outputs.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - pix_ready = (count<FIFO_DEPTH) when out of reset.
  - Push and pop in the same cycle: count unchanged.
  - Push into an empty FIFO with a coincident pop demand: no bypass; the pop counts as an underflow and the pushed pixel is retained.
- Flush:
  - On the pix_en cycle where h==0 && v==V_ACTIVE (start of vblank), the FIFO is emptied.
  - A push in that same cycle is dropped; flush wins.
  - This realigns software to frame_start after any underflow.
- Wrap-around: pointers wrap modulo FIFO_DEPTH; the count never exceeds FIFO_DEPTH or goes below 0.
- Reset asserted mid-frame: the next Clk returns every output to its reset value and discards FIFO contents. Counting restarts from h=0,v=0 after release, so frame_start fires on the first pix_en after release.

Test Plan:
- Reset -> hold Reset_n=0 for 4 Clk with pix_valid=1: pix_ready=0, VGA_HS=VGA_VS=1, BLANK_N=0, RGB=0, underflow_cnt=0. First pix_en after release gives frame_start=1.
- Timing, no pixels supplied:
  - VGA_HS low for exactly 192 Clk per line; line period 1600 Clk.
  - VGA_VS low for 2 lines (3200 Clk); frame period 840000 Clk; BLANK_N high 1280 Clk per line.
  - underflow_cnt=307200 saturates to 0xFFFF after the first frame.
- FIFO full -> push 16 pixels during vblank: pix_ready drops on the Clk after the 16th push. 17th pix_valid is ignored. Count stays 16.
- Ordering -> preload 0x000001..0x000010, keep feeding an incrementing pattern at ≥1 pixel per 2 Clk: first active pixel of the frame shows 0x000001 on {R,G,B}, the next pixel tick shows 0x000002, and underflow_cnt does not change.
- Underflow and flush:
  - Supply 600 pixels and stop: pixels 601..640 of line 0 are black and underflow_cnt increments by 1 per active tick.
  - A push on the flush cycle (h=0,v=480) is dropped; FIFO count=0 after it.
- Reset mid-line -> assert Reset_n at h=300,v=100 with FIFO holding 8: next Clk gives RGB=0, FIFO count=0. After release, h/v restart at 0.
